// File: rtl/ttl_mux_reg_scan_pkg.sv
// Shared types and helpers for the registered scanning mux bank.
// The select-width helper keeps a single-input bank at one select bit.
package ttl_mux_reg_scan_pkg;

    typedef enum logic {
        MODE_DIRECT = 1'b0,
        MODE_SCAN   = 1'b1
    } mode_e;

    function automatic int sel_width(input int n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ttl_scan_counter.sv
// Scan counter with load and a one-cycle wrap pulse.
// The counter wraps from LAST to 0; Load takes priority over running.
module ttl_scan_counter #(
    parameter int WIDTH = 1,
    parameter int LAST  = 1
) (
    input  logic             Clk,
    input  logic             Reset_n,
    input  logic             Cen,
    input  logic             Run,
    input  logic             Load,
    input  logic [WIDTH-1:0] D,
    output logic [WIDTH-1:0] Q,
    output logic             Wrap
);

    localparam logic [WIDTH-1:0] LP_LAST = WIDTH'(LAST);

    logic [WIDTH-1:0] r_q;
    logic             r_wrap;
    logic             w_at_last;

    assign w_at_last = (r_q == LP_LAST);

    // Wrap is cleared on idle Cen cycles so it never stretches across a stall.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_q    <= '0;
            r_wrap <= 1'b0;
        end else if (Cen) begin
            r_wrap <= Run & ~Load & w_at_last;
            if (Load)
                r_q <= (D > LP_LAST) ? '0 : D;
            else if (Run)
                r_q <= w_at_last ? '0 : r_q + WIDTH'(1);
        end else begin
            r_wrap <= 1'b0;
        end
    end

    assign Q    = r_q;
    assign Wrap = r_wrap;

endmodule

// File: rtl/ttl_mux_reg_scan.sv
// Registered BLOCKS x WIDTH_IN mux bank with direct or scanned selection.
// Disabled or out-of-range selection registers OFF_VALUE on every channel.
module ttl_mux_reg_scan
    import ttl_mux_reg_scan_pkg::*;
#(
    parameter int   BLOCKS       = 4,
    parameter int   WIDTH_IN     = 2,
    parameter int   WIDTH_SELECT = sel_width(WIDTH_IN),
    parameter int   SCAN_LAST    = WIDTH_IN - 1,
    parameter logic OFF_VALUE    = 1'b1
) (
    input  logic                         Clk,
    input  logic                         Reset_n,
    input  logic                         Cen,
    input  logic                         Enable_bar,
    input  logic                         Mode,
    input  logic                         Load,
    input  logic [WIDTH_SELECT-1:0]      Select,
    input  logic [BLOCKS*WIDTH_IN-1:0]   A_2D,
    output logic [BLOCKS-1:0]            Y,
    output logic [WIDTH_SELECT-1:0]      Sel_out,
    output logic                         Wrap
);

    localparam logic [WIDTH_SELECT:0] LP_WIDTH_IN = (WIDTH_SELECT + 1)'(WIDTH_IN);

    logic [WIDTH_IN-1:0]     w_chan [BLOCKS];
    logic [WIDTH_SELECT-1:0] w_cnt;
    logic [WIDTH_SELECT-1:0] w_eff_sel;
    logic                    w_scan;
    logic                    w_in_range;
    logic [BLOCKS-1:0]       w_y_next;

    logic [BLOCKS-1:0]       r_y;
    logic [WIDTH_SELECT-1:0] r_sel;

    for (genvar gi = 0; gi < BLOCKS; gi++) begin : g_unpack
        assign w_chan[gi] = A_2D[gi*WIDTH_IN +: WIDTH_IN];
    end

    ttl_scan_counter #(
        .WIDTH (WIDTH_SELECT),
        .LAST  (SCAN_LAST)
    ) u_cnt (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Cen     (Cen),
        .Run     (w_scan),
        .Load    (Load),
        .D       (Select),
        .Q       (w_cnt),
        .Wrap    (Wrap)
    );

    assign w_scan     = (Mode == MODE_SCAN);
    assign w_eff_sel  = w_scan ? w_cnt : Select;
    assign w_in_range = ({1'b0, w_eff_sel} < LP_WIDTH_IN);

    // Scan mode picks with the pre-increment count, so Sel_out names the source of Y.
    always_comb begin
        w_y_next = {BLOCKS{OFF_VALUE}};
        if (!Enable_bar && w_in_range) begin
            for (int i = 0; i < BLOCKS; i++)
                w_y_next[i] = w_chan[i][w_eff_sel];
        end
    end

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            r_y   <= {BLOCKS{OFF_VALUE}};
            r_sel <= '0;
        end else if (Cen) begin
            r_y   <= w_y_next;
            r_sel <= w_eff_sel;
        end
    end

    assign Y       = r_y;
    assign Sel_out = r_sel;

endmodule

// File: tb/tb_ttl_mux_reg_scan.sv
// Directed bench for ttl_mux_reg_scan: 2-input, 3-input and single-step scan instances.
module tb_ttl_mux_reg_scan;

    typedef struct {
        logic        rst_n;
        logic        cen;
        logic        en_bar;
        logic        mode;
        logic        load;
        logic [1:0]  sel;
        logic [11:0] a;
        logic [3:0]  y;
        logic [1:0]  so;
        logic        wr;
    } vec_t;

    logic Clk = 1'b0;
    always #5 Clk = ~Clk;

    logic       a_rst_n, a_cen, a_enb, a_mode, a_load;
    logic [0:0] a_sel;
    logic [7:0] a_a;
    logic [3:0] y2, y0;
    logic [0:0] so2, so0;
    logic       wr2, wr0;

    logic        b_rst_n, b_cen, b_enb, b_mode, b_load;
    logic [1:0]  b_sel;
    logic [11:0] b_a;
    logic [3:0]  y3;
    logic [1:0]  so3;
    logic        wr3;

    int n_vec = 0;
    int n_bad = 0;

    vec_t v2 [14];
    vec_t v3 [26];

    ttl_mux_reg_scan dut2 (
        .Clk(Clk), .Reset_n(a_rst_n), .Cen(a_cen), .Enable_bar(a_enb), .Mode(a_mode),
        .Load(a_load), .Select(a_sel), .A_2D(a_a), .Y(y2), .Sel_out(so2), .Wrap(wr2)
    );

    ttl_mux_reg_scan #(.WIDTH_IN(2), .SCAN_LAST(0)) dut0 (
        .Clk(Clk), .Reset_n(a_rst_n), .Cen(a_cen), .Enable_bar(a_enb), .Mode(a_mode),
        .Load(a_load), .Select(a_sel), .A_2D(a_a), .Y(y0), .Sel_out(so0), .Wrap(wr0)
    );

    ttl_mux_reg_scan #(.WIDTH_IN(3)) dut3 (
        .Clk(Clk), .Reset_n(b_rst_n), .Cen(b_cen), .Enable_bar(b_enb), .Mode(b_mode),
        .Load(b_load), .Select(b_sel), .A_2D(b_a), .Y(y3), .Sel_out(so3), .Wrap(wr3)
    );

    task automatic chk(input string nm, input int idx, input logic [11:0] act, input logic [11:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s[%0d]: got %h, expected %h", nm, idx, act, exp);
        end
    endtask

    task automatic edge_wait;
        @(posedge Clk);
        #1;
    endtask

    task automatic drive_a(input logic rst_n, input logic cen, input logic enb, input logic mode,
                           input logic load, input logic sel, input logic [7:0] a);
        a_rst_n = rst_n; a_cen = cen; a_enb = enb; a_mode = mode; a_load = load; a_sel = sel; a_a = a;
    endtask

    task automatic drive_b(input logic rst_n, input logic cen, input logic enb, input logic mode,
                           input logic load, input logic [1:0] sel, input logic [11:0] a);
        b_rst_n = rst_n; b_cen = cen; b_enb = enb; b_mode = mode; b_load = load; b_sel = sel; b_a = a;
    endtask

    initial begin
        int cyc;
        bit seen;

        // rst_n cen en_bar mode load sel a  | y so wr
        v2[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 12'h099, 4'hF,    2'd0, 1'b0};
        v2[1]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 12'h099, 4'b1010, 2'd1, 1'b0};
        v2[2]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 12'h099, 4'hF,    2'd0, 1'b0};
        v2[3]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 12'h099, 4'b1010, 2'd1, 1'b0};
        v2[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 12'h099, 4'b0101, 2'd0, 1'b0};
        v2[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 2'd1, 12'h099, 4'b0101, 2'd0, 1'b0};
        v2[6]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd1, 12'h099, 4'hF,    2'd1, 1'b0};
        v2[7]  = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'd0, 12'h000, 4'hF,    2'd0, 1'b0};
        v2[8]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 12'h000, 4'h0,    2'd0, 1'b0};
        v2[9]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd1, 12'h0FF, 4'hF,    2'd1, 1'b0};
        v2[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'h099, 4'b0101, 2'd0, 1'b0};
        v2[11] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'h099, 4'b1010, 2'd1, 1'b1};
        v2[12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 12'h099, 4'b1010, 2'd1, 1'b0};
        v2[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'h099, 4'b0101, 2'd0, 1'b0};

        // Channels 001/010/100/111: sel0 -> 1001, sel1 -> 1010, sel2 -> 1100, sel3 -> OFF
        v3[0]  = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 12'hF11, 4'hF,    2'd0, 1'b0};
        v3[1]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'hF11, 4'b1001, 2'd0, 1'b0};
        v3[2]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'hF11, 4'b1010, 2'd1, 1'b0};
        v3[3]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'hF11, 4'b1100, 2'd2, 1'b1};
        v3[4]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'hF11, 4'b1001, 2'd0, 1'b0};
        v3[5]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'hF11, 4'b1010, 2'd1, 1'b0};
        v3[6]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 12'hF11, 4'b1010, 2'd1, 1'b0};
        v3[7]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 12'hF11, 4'b1010, 2'd1, 1'b0};
        v3[8]  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 12'hF11, 4'b1010, 2'd1, 1'b0};
        v3[9]  = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'hF11, 4'b1100, 2'd2, 1'b1};
        v3[10] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'hF11, 4'b1001, 2'd0, 1'b0};
        v3[11] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd3, 12'hF11, 4'hF,    2'd3, 1'b0};
        v3[12] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 2'd3, 12'hF11, 4'hF,    2'd3, 1'b0};
        v3[13] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'hF11, 4'b1001, 2'd0, 1'b0};
        v3[14] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'hF11, 4'b1010, 2'd1, 1'b0};
        v3[15] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 2'd1, 12'hF11, 4'b1100, 2'd2, 1'b0};
        v3[16] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'hF11, 4'b1010, 2'd1, 1'b0};
        v3[17] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 12'hF11, 4'b1001, 2'd0, 1'b0};
        v3[18] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'hF11, 4'b1100, 2'd2, 1'b1};
        v3[19] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'd0, 12'hF11, 4'hF,    2'd0, 1'b0};
        v3[20] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'hF11, 4'b1010, 2'd1, 1'b0};
        v3[21] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'hF11, 4'hF,    2'd0, 1'b0};
        v3[22] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'hF11, 4'b1001, 2'd0, 1'b0};
        v3[23] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'hF11, 4'b1010, 2'd1, 1'b0};
        v3[24] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'hF11, 4'b1100, 2'd2, 1'b1};
        v3[25] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 12'hF11, 4'b1100, 2'd2, 1'b0};

        drive_a(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        drive_b(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 12'h000);

        for (int i = 0; i < 14; i++) begin
            drive_a(v2[i].rst_n, v2[i].cen, v2[i].en_bar, v2[i].mode, v2[i].load, v2[i].sel[0], v2[i].a[7:0]);
            edge_wait();
            chk("w2_y",    i, {8'h0, y2},         {8'h0, v2[i].y});
            chk("w2_sel",  i, {11'h0, so2},       {11'h0, v2[i].so[0]});
            chk("w2_wrap", i, {11'h0, wr2},       {11'h0, v2[i].wr});
        end

        for (int i = 0; i < 26; i++) begin
            drive_b(v3[i].rst_n, v3[i].cen, v3[i].en_bar, v3[i].mode, v3[i].load, v3[i].sel, v3[i].a);
            edge_wait();
            chk("w3_y",    i, {8'h0, y3},         {8'h0, v3[i].y});
            chk("w3_sel",  i, {10'h0, so3},       {10'h0, v3[i].so});
            chk("w3_wrap", i, {11'h0, wr3},       {11'h0, v3[i].wr});
        end

        // Single-value scan range: Wrap on every enabled edge, count pinned at 0.
        drive_a(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h99);
        edge_wait();
        chk("l0_reset_wrap", 0, {11'h0, wr0}, 12'h000);
        for (int i = 0; i < 3; i++) begin
            drive_a(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 8'h99);
            edge_wait();
            chk("l0_wrap", i, {11'h0, wr0}, 12'h001);
            chk("l0_sel",  i, {11'h0, so0}, 12'h000);
            chk("l0_y",    i, {8'h0, y0},   {8'h0, 4'b0101});
        end
        drive_a(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h99);
        edge_wait();
        chk("l0_cen_off_wrap", 0, {11'h0, wr0}, 12'h000);

        // From reset, the first Wrap of a 3-step scan lands on the third edge and lasts one cycle.
        drive_b(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'hF11);
        edge_wait();
        drive_b(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'd0, 12'hF11);
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 8) begin
            edge_wait();
            cyc++;
            if (wr3 === 1'b1) seen = 1'b1;
        end
        if (!seen) begin
            n_vec++;
            n_bad++;
            $display("FAIL wrap_wait: no Wrap within %0d cycles, expected on cycle 3", cyc);
        end else begin
            chk("wrap_cycle", 0, 12'(cyc), 12'd3);
        end
        edge_wait();
        chk("wrap_single", 0, {11'h0, wr3}, 12'h000);
        chk("wrap_after_sel", 0, {10'h0, so3}, 12'h000);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
